// File: rtl/axi_ar_crossbar_if.sv
// axi_ar_crossbar_if: AR-channel bundle between masters, slaves, the decode-error path and the crossbar.
interface axi_ar_crossbar_if #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 3,
  parameter int ID_BITS   = 4,
  parameter int MIDX_BITS = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3
);
  localparam int IDS_BITS = MIDX_BITS + ID_BITS;
  logic [NUM_M*ID_BITS-1:0]   ARID_M;
  logic [NUM_M*ADDR_BITS-1:0] ARADDR_M;
  logic [NUM_M*LEN_BITS-1:0]  ARLEN_M;
  logic [NUM_M*SIZE_BITS-1:0] ARSIZE_M;
  logic [NUM_M*2-1:0]         ARBURST_M;
  logic [NUM_M-1:0]           ARVALID_M;
  logic [NUM_M-1:0]           ARREADY_M;
  logic [NUM_S*IDS_BITS-1:0]  ARID_S;
  logic [NUM_S*ADDR_BITS-1:0] ARADDR_S;
  logic [NUM_S*LEN_BITS-1:0]  ARLEN_S;
  logic [NUM_S*SIZE_BITS-1:0] ARSIZE_S;
  logic [NUM_S*2-1:0]         ARBURST_S;
  logic [NUM_S-1:0]           ARVALID_S;
  logic [NUM_S-1:0]           ARREADY_S;
  logic                       DERR_VALID;
  logic [IDS_BITS-1:0]        DERR_ID;
  logic [LEN_BITS-1:0]        DERR_LEN;
  logic                       DERR_READY;
  logic                       GNT_BUSY;
  modport master (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, ARREADY_S, DERR_READY,
    input  ARREADY_M, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
           DERR_VALID, DERR_ID, DERR_LEN, GNT_BUSY
  );
  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, ARREADY_S, DERR_READY,
    output ARREADY_M, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
           DERR_VALID, DERR_ID, DERR_LEN, GNT_BUSY
  );
endinterface

// File: rtl/axi_ar_crossbar.sv
// axi_ar_crossbar: round-robin AR router with address decode, ID extension and local decode-error absorption.
module axi_ar_crossbar #(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 3,
  parameter int ID_BITS   = 4,
  parameter int MIDX_BITS = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter logic [NUM_S*ADDR_BITS-1:0] S_BASE = {32'h2000_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_S*ADDR_BITS-1:0] S_MASK = {32'hFFE0_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
  input logic ACLK,
  input logic ARESETn,
  axi_ar_crossbar_if.slave bus
);
  localparam int IDS_BITS = MIDX_BITS + ID_BITS;
  localparam int MW = NUM_M > 1 ? $clog2(NUM_M) : 1;
  localparam int SW = NUM_S > 1 ? $clog2(NUM_S) : 1;
  typedef enum logic [1:0] {IDLE, FWD, DERR} state_t;
  state_t              state_q;
  logic [MW-1:0]       gnt_m_q, rr_q, pick_m_d, rr_d;
  logic [SW-1:0]       gnt_s_q, pick_s_d;
  logic                pick_ok, hit, g_vld;
  logic [ADDR_BITS-1:0] pick_addr;
  logic [IDS_BITS-1:0] g_id;
  logic [LEN_BITS-1:0] g_len;
  // first valid master from rr_q onward, then decode its address (lowest slave index wins)
  always_comb begin
    pick_ok = 1'b0;
    pick_m_d = '0;
    for (int k = 0; k < NUM_M; k++)
      if (!pick_ok && bus.ARVALID_M[(int'(rr_q) + k) % NUM_M]) begin
        pick_ok = 1'b1;
        pick_m_d = MW'((int'(rr_q) + k) % NUM_M);
      end
    pick_addr = bus.ARADDR_M[pick_m_d*ADDR_BITS +: ADDR_BITS];
    hit = 1'b0;
    pick_s_d = '0;
    for (int s = NUM_S - 1; s >= 0; s--)
      if ((pick_addr & S_MASK[s*ADDR_BITS +: ADDR_BITS]) == S_BASE[s*ADDR_BITS +: ADDR_BITS]) begin
        hit = 1'b1;
        pick_s_d = SW'(s);
      end
  end
  assign rr_d  = gnt_m_q == MW'(NUM_M - 1) ? '0 : gnt_m_q + MW'(1);
  assign g_vld = bus.ARVALID_M[gnt_m_q];
  assign g_id  = {MIDX_BITS'(gnt_m_q), bus.ARID_M[gnt_m_q*ID_BITS +: ID_BITS]};
  assign g_len = bus.ARLEN_M[gnt_m_q*LEN_BITS +: LEN_BITS];
  always_comb begin
    bus.ARREADY_M  = '0;
    bus.ARID_S     = '0;
    bus.ARADDR_S   = '0;
    bus.ARLEN_S    = '0;
    bus.ARSIZE_S   = '0;
    bus.ARBURST_S  = '0;
    bus.ARVALID_S  = '0;
    bus.DERR_VALID = state_q == DERR;
    bus.DERR_ID    = state_q == DERR ? g_id : '0;
    bus.DERR_LEN   = state_q == DERR ? g_len : '0;
    bus.GNT_BUSY   = state_q != IDLE;
    if (state_q == FWD) begin
      bus.ARVALID_S[gnt_s_q]                        = g_vld;
      bus.ARID_S[gnt_s_q*IDS_BITS +: IDS_BITS]      = g_id;
      bus.ARADDR_S[gnt_s_q*ADDR_BITS +: ADDR_BITS]  = bus.ARADDR_M[gnt_m_q*ADDR_BITS +: ADDR_BITS];
      bus.ARLEN_S[gnt_s_q*LEN_BITS +: LEN_BITS]     = g_len;
      bus.ARSIZE_S[gnt_s_q*SIZE_BITS +: SIZE_BITS]  = bus.ARSIZE_M[gnt_m_q*SIZE_BITS +: SIZE_BITS];
      bus.ARBURST_S[gnt_s_q*2 +: 2]                 = bus.ARBURST_M[gnt_m_q*2 +: 2];
      bus.ARREADY_M[gnt_m_q]                        = bus.ARREADY_S[gnt_s_q];
    end
    if (state_q == DERR)
      bus.ARREADY_M[gnt_m_q] = bus.DERR_READY;
  end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state_q <= IDLE;
      gnt_m_q <= '0;
      gnt_s_q <= '0;
      rr_q    <= '0;
    end else
      case (state_q)
        IDLE: if (pick_ok) begin
          gnt_m_q <= pick_m_d;
          gnt_s_q <= pick_s_d;
          state_q <= hit ? FWD : DERR;
        end
        // a dropped ARVALID abandons the grant without advancing the pointer
        FWD: if (!g_vld || bus.ARREADY_S[gnt_s_q]) begin
          state_q <= IDLE;
          if (g_vld) rr_q <= rr_d;
        end
        DERR: if (bus.DERR_READY) begin
          state_q <= IDLE;
          rr_q    <= rr_d;
        end
        default: state_q <= IDLE;
      endcase
endmodule
